regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have: clk_i  in  1  sole clock, all state on posedge.
REQ-002 SHALL have: rst_n_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: req_valid_i  in  3  writeback request per requester (0=ALU, 1=LSU, 2=MULDIV).
REQ-004 SHALL have: req_rd_i  in  15  destination address, requester k at bits [5k+4:5k].
REQ-005 SHALL have: req_data_i  in  96  writeback data, requester k at bits [32k+31:32k].
REQ-006 SHALL have: req_ready_o  out  3  one-hot grant; transfer on valid&ready.
REQ-007 SHALL have: issue_valid_i  in  1, issue_rd_i  in  5  marks a destination pending.
REQ-008 SHALL have: RS1_address_i, RS2_address_i  in  5 each; RS1_busy_o, RS2_busy_o  out  1 each.
REQ-009 SHALL have: flush_i  in  1  pipeline flush; flush_done_o  out  1  one-cycle pulse.
REQ-010 SHALL have: RegWrite_o  out  1, RD_address_o  out  5, RD_data_o  out  32  register-file write port, registered.
REQ-011 SHALL have: pending_o  out  32  scoreboard, bit n = x(n) awaiting writeback.

Function
REQ-012 SHALL grant at most one requester per cycle; req_ready_o[k]=1 only if req_valid_i[k]=1 and state RUN.
REQ-013 SHALL, default policy, grant fixed priority 0 > 1 > 2.
REQ-014 SHALL register the accepted request: RegWrite_o=1, RD_address_o, RD_data_o valid the cycle after transfer (latency 1); RegWrite_o=0 in cycles with no transfer.
REQ-015 SHALL accept a request with rd=0 but keep RegWrite_o=0 for it.
REQ-016 SHALL hold RD_address_o/RD_data_o stable when RegWrite_o=0.
REQ-017 SHALL set pending[rd] on posedge with issue_valid_i=1 and issue_rd_i!=0, state RUN.
REQ-018 SHALL clear pending[RD_address_o] on posedge with RegWrite_o=1 (the edge the register file commits).
REQ-019 SHALL, on same-edge set and clear of one address, leave the bit set.
REQ-020 SHALL keep pending[0]=0 always; RSn_busy_o = pending[RSn_address_i], combinational.
REQ-021 SHALL implement FSM RUN/DRAIN: RUN->DRAIN on flush_i=1; DRAIN->RUN unconditionally after one cycle.
REQ-022 SHALL, in DRAIN, drive req_ready_o=0, ignore issue_valid_i, let the in-flight RegWrite_o complete, clear all pending bits on exit, and pulse flush_done_o=1 for the DRAIN cycle.
REQ-023 SHALL ignore flush_i while in DRAIN.

Reset
REQ-024 SHALL, while rst_n_i=0 regardless of clock: RegWrite_o=0, RD_address_o=0, RD_data_o=0, pending_o=0, flush_done_o=0, state RUN, round-robin pointer=2.
REQ-025 SHALL drive req_ready_o=0 and RSn_busy_o=0 during reset; a write registered before reset is discarded.

Configuration
REQ-026 SHALL, with WB_ROUND_ROBIN_EN defined, use round-robin: search starts at (last granted + 1) mod 3, pointer updates only on transfer.
REQ-027 SHALL, without WB_ROUND_ROBIN_EN, use fixed priority of REQ-013 and contain no pointer register.

Structure
REQ-028 SHALL place NUM_REQ=3, address/data widths, requester index constants and the RUN/DRAIN state encoding in shared package regfile_ctrl_pkg.
REQ-029 SHALL implement grant selection in one sub-module wb_grant_sel (fixed or round-robin per macro).

Verification
REQ-030 Reset: rst_n_i=0 mid-cycle with RegWrite_o=1 -> RegWrite_o=0, pending_o=0 immediately.
REQ-031 Priority: valid=3'b111 rd=5,6,7 -> fixed: writes x5,x6,x7 over 3 cycles; RR: same order then pointer=2.
REQ-032 Scoreboard: issue rd=9, RS1_address_i=9 -> RS1_busy_o=1 until edge after RegWrite_o=1 with RD_address_o=9, then 0.
REQ-033 Collision: RegWrite_o=1 rd=4 and issue_rd_i=4 same cycle -> pending_o[4] stays 1.
REQ-034 x0: requester 1 rd=0 data=32'hDEADBEEF -> ready=1, RegWrite_o stays 0; issue rd=0 -> pending_o[0]=0.
REQ-035 Flush: pending_o=32'h0000_0300, flush_i=1 -> ready=0 one cycle, flush_done_o pulse, then pending_o=0, state RUN.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared constants and state encoding for the writeback arbiter
package regfile_ctrl_pkg;
    localparam int NUM_REQ  = 3;
    localparam int IDX_W    = 2;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    localparam logic [IDX_W-1:0] REQ_ALU    = 2'd0;
    localparam logic [IDX_W-1:0] REQ_LSU    = 2'd1;
    localparam logic [IDX_W-1:0] REQ_MULDIV = 2'd2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } wb_state_e;

    function automatic logic [IDX_W-1:0] req_wrap(input int v);
        int r;
        r = v % NUM_REQ;
        return r[IDX_W-1:0];
    endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - request/grant bundle between the arbiter and its grant selector
interface regfile_wb_arbiter_if;
    import regfile_ctrl_pkg::*;

    logic [NUM_REQ-1:0] valid;
    logic               en;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;

    modport master (output valid, output en, input gnt, input gnt_idx);
    modport slave  (input valid, input en, output gnt, output gnt_idx);
endinterface

// File: rtl/wb_grant_sel.sv
// rtl/wb_grant_sel.sv - one-hot writeback grant; fixed 0>1>2, or round-robin with WB_ROUND_ROBIN_EN
module wb_grant_sel
    import regfile_ctrl_pkg::*;
(
`ifdef WB_ROUND_ROBIN_EN
    input  logic                 clk_i,
    input  logic                 rst_n_i,
`endif
    regfile_wb_arbiter_if.slave  bus
);
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

`ifdef WB_ROUND_ROBIN_EN
    // Pointer holds the last granted requester; reset value makes the first search start at 0.
    logic [IDX_W-1:0] r_ptr;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ptr <= REQ_MULDIV;
        end else if (w_found) begin
            r_ptr <= bus.gnt_idx;
        end
    end
`endif

    always_comb begin
        bus.gnt     = '0;
        bus.gnt_idx = REQ_ALU;
        w_found     = 1'b0;
        w_cand      = REQ_ALU;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef WB_ROUND_ROBIN_EN
            w_cand = req_wrap(int'(r_ptr) + 1 + i);
`else
            w_cand = req_wrap(i);
`endif
            if (bus.en && !w_found && bus.valid[w_cand]) begin
                w_found          = 1'b1;
                bus.gnt[w_cand]  = 1'b1;
                bus.gnt_idx      = w_cand;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - writeback arbiter, register-file write port and pending scoreboard (WB_ROUND_ROBIN_EN selects round-robin)
module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_rd_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic                        issue_valid_i,
    input  logic [ADDR_W-1:0]           issue_rd_i,
    input  logic [ADDR_W-1:0]           RS1_address_i,
    input  logic [ADDR_W-1:0]           RS2_address_i,
    output logic                        RS1_busy_o,
    output logic                        RS2_busy_o,
    input  logic                        flush_i,
    output logic                        flush_done_o,
    output logic                        RegWrite_o,
    output logic [ADDR_W-1:0]           RD_address_o,
    output logic [DATA_W-1:0]           RD_data_o,
    output logic [NUM_REGS-1:0]         pending_o
);
    wb_state_e           r_state;
    logic                r_flush_done;
    logic                r_reg_write;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [DATA_W-1:0]   r_rd_data;
    logic [NUM_REGS-1:0] r_pending;

    logic                w_xfer;
    logic                w_commit;
    logic [ADDR_W-1:0]   w_sel_rd;
    logic [DATA_W-1:0]   w_sel_data;
    logic [NUM_REGS-1:0] w_pending_nxt;

    regfile_wb_arbiter_if w_bus ();

    // Gating with rst_n_i keeps ready low for the whole reset, not just after the first edge.
    assign w_bus.valid = req_valid_i;
    assign w_bus.en    = rst_n_i && (r_state == ST_RUN);

    wb_grant_sel u_sel (
`ifdef WB_ROUND_ROBIN_EN
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
`endif
        .bus     (w_bus)
    );

    assign req_ready_o = w_bus.gnt;
    assign w_xfer      = |w_bus.gnt;

    always_comb begin
        w_sel_rd   = req_rd_i[ADDR_W-1:0];
        w_sel_data = req_data_i[DATA_W-1:0];
        case (w_bus.gnt_idx)
            REQ_LSU: begin
                w_sel_rd   = req_rd_i[2*ADDR_W-1:ADDR_W];
                w_sel_data = req_data_i[2*DATA_W-1:DATA_W];
            end
            REQ_MULDIV: begin
                w_sel_rd   = req_rd_i[3*ADDR_W-1:2*ADDR_W];
                w_sel_data = req_data_i[3*DATA_W-1:2*DATA_W];
            end
            default: ;
        endcase
    end

    // x0 writes are accepted from the requester but never reach the register file.
    assign w_commit = w_xfer && (w_sel_rd != '0);

    // Set after clear so a same-edge issue to the retiring address stays pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_reg_write) begin
            w_pending_nxt[r_rd_addr] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != '0) && (r_state == ST_RUN)) begin
            w_pending_nxt[issue_rd_i] = 1'b1;
        end
        if (r_state == ST_DRAIN) begin
            w_pending_nxt = '0;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= ST_RUN;
            r_flush_done <= 1'b0;
            r_reg_write  <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_data    <= '0;
            r_pending    <= '0;
        end else begin
            r_reg_write <= w_commit;
            if (w_commit) begin
                r_rd_addr <= w_sel_rd;
                r_rd_data <= w_sel_data;
            end
            r_pending <= w_pending_nxt;
            case (r_state)
                ST_RUN: begin
                    if (flush_i) begin
                        r_state      <= ST_DRAIN;
                        r_flush_done <= 1'b1;
                    end else begin
                        r_flush_done <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    r_state      <= ST_RUN;
                    r_flush_done <= 1'b0;
                end
                default: begin
                    r_state      <= ST_RUN;
                    r_flush_done <= 1'b0;
                end
            endcase
        end
    end

    assign RegWrite_o   = r_reg_write;
    assign RD_address_o = r_rd_addr;
    assign RD_data_o    = r_rd_data;
    assign pending_o    = r_pending;
    assign flush_done_o = r_flush_done;
    assign RS1_busy_o   = r_pending[RS1_address_i];
    assign RS2_busy_o   = r_pending[RS2_address_i];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [14:0] req_rd_i;
    logic [95:0] req_data_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic [4:0]  RS1_address_i;
    logic [4:0]  RS2_address_i;
    logic        RS1_busy_o;
    logic        RS2_busy_o;
    logic        flush_i;
    logic        flush_done_o;
    logic        RegWrite_o;
    logic [4:0]  RD_address_o;
    logic [31:0] RD_data_o;
    logic [31:0] pending_o;
    logic [2:0]  exp_policy;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_arbiter_if tb_bus ();

    always #5 clk_i = ~clk_i;

    regfile_wb_arbiter u_dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .req_valid_i   (tb_bus.valid),
        .req_rd_i      (req_rd_i),
        .req_data_i    (req_data_i),
        .req_ready_o   (tb_bus.gnt),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .RS1_address_i (RS1_address_i),
        .RS2_address_i (RS2_address_i),
        .RS1_busy_o    (RS1_busy_o),
        .RS2_busy_o    (RS2_busy_o),
        .flush_i       (flush_i),
        .flush_done_o  (flush_done_o),
        .RegWrite_o    (RegWrite_o),
        .RD_address_o  (RD_address_o),
        .RD_data_o     (RD_data_o),
        .pending_o     (pending_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_n_i       = 1'b0;
        tb_bus.valid  = 3'b111;
        req_rd_i      = '0;
        req_data_i    = '0;
        issue_valid_i = 1'b0;
        issue_rd_i    = '0;
        RS1_address_i = '0;
        RS2_address_i = '0;
        flush_i       = 1'b0;
        #2;
        check("rst_regwrite",   32'(RegWrite_o),   32'd0);
        check("rst_pending",    pending_o,         32'd0);
        check("rst_ready",      32'(tb_bus.gnt),   32'd0);
        check("rst_flush_done", 32'(flush_done_o), 32'd0);
        step();
        step();
        check("rst_ready_edge", 32'(tb_bus.gnt),   32'd0);
        check("rst_rd_data",    RD_data_o,         32'd0);
        tb_bus.valid = 3'b000;
        rst_n_i      = 1'b1;
        step();

        // Fixed-priority order with all three requesting.
        req_rd_i     = {5'd7, 5'd6, 5'd5};
        req_data_i   = {32'h0000_C0C7, 32'h0000_B0B6, 32'h0000_A0A5};
        tb_bus.valid = 3'b111;
        #1;
        check("prio_gnt0", 32'(tb_bus.gnt), 32'h1);
        step();
        tb_bus.valid = 3'b110;
        #1;
        check("prio_wr5_we",   32'(RegWrite_o),   32'd1);
        check("prio_wr5_addr", 32'(RD_address_o), 32'd5);
        check("prio_wr5_data", RD_data_o,         32'h0000_A0A5);
        check("prio_gnt1",     32'(tb_bus.gnt),   32'h2);
        step();
        tb_bus.valid = 3'b100;
        #1;
        check("prio_wr6_addr", 32'(RD_address_o), 32'd6);
        check("prio_wr6_data", RD_data_o,         32'h0000_B0B6);
        check("prio_gnt2",     32'(tb_bus.gnt),   32'h4);
        step();
        tb_bus.valid = 3'b000;
        #1;
        check("prio_wr7_we",   32'(RegWrite_o),   32'd1);
        check("prio_wr7_addr", 32'(RD_address_o), 32'd7);
        check("prio_wr7_data", RD_data_o,         32'h0000_C0C7);
        step();
        check("idle_we",        32'(RegWrite_o),   32'd0);
        check("idle_hold_addr", 32'(RD_address_o), 32'd7);
        check("idle_hold_data", RD_data_o,         32'h0000_C0C7);

        // After granting requester 0, a 0+1 contention separates the policies.
        tb_bus.valid = 3'b001;
        step();
        tb_bus.valid = 3'b011;
        #1;
`ifdef WB_ROUND_ROBIN_EN
        exp_policy = 3'b010;
`else
        exp_policy = 3'b001;
`endif
        check("policy_gnt", 32'(tb_bus.gnt), 32'(exp_policy));
        tb_bus.valid = 3'b000;
        step();
        step();

        // Scoreboard set and clear on writeback commit.
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd9;
        RS1_address_i = 5'd9;
        RS2_address_i = 5'd5;
        #1;
        check("sb_busy_pre", 32'(RS1_busy_o), 32'd0);
        step();
        issue_valid_i = 1'b0;
        check("sb_pending9", pending_o,         32'h0000_0200);
        check("sb_busy1",    32'(RS1_busy_o),   32'd1);
        check("sb_busy2",    32'(RS2_busy_o),   32'd0);
        req_rd_i     = {5'd0, 5'd9, 5'd0};
        req_data_i   = {32'h0, 32'h0000_0099, 32'h0};
        tb_bus.valid = 3'b010;
        #1;
        check("sb_gnt_lsu", 32'(tb_bus.gnt), 32'h2);
        step();
        tb_bus.valid = 3'b000;
        check("sb_wr_we",        32'(RegWrite_o),   32'd1);
        check("sb_wr_addr",      32'(RD_address_o), 32'd9);
        check("sb_busy_at_wr",   32'(RS1_busy_o),   32'd1);
        step();
        check("sb_busy_after",   32'(RS1_busy_o),   32'd0);
        check("sb_pending_clr",  pending_o,         32'd0);

        // Same-edge clear and set of x4.
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd4;
        step();
        issue_valid_i = 1'b0;
        check("col_pending_set", pending_o, 32'h0000_0010);
        req_rd_i     = {5'd0, 5'd0, 5'd4};
        req_data_i   = {32'h0, 32'h0, 32'h0000_0044};
        tb_bus.valid = 3'b001;
        step();
        tb_bus.valid  = 3'b000;
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd4;
        check("col_wr_addr", 32'(RD_address_o), 32'd4);
        step();
        issue_valid_i = 1'b0;
        check("col_pending_kept", pending_o, 32'h0000_0010);
        tb_bus.valid = 3'b001;
        step();
        tb_bus.valid = 3'b000;
        step();
        check("col_pending_clr", pending_o, 32'd0);

        // x0 destination: accepted but never written or marked pending.
        req_rd_i     = {5'd0, 5'd0, 5'd0};
        req_data_i   = {32'h0, 32'hDEAD_BEEF, 32'h0};
        tb_bus.valid = 3'b010;
        #1;
        check("x0_gnt", 32'(tb_bus.gnt), 32'h2);
        step();
        tb_bus.valid = 3'b000;
        check("x0_we",        32'(RegWrite_o),   32'd0);
        check("x0_hold_addr", 32'(RD_address_o), 32'd4);
        check("x0_hold_data", RD_data_o,         32'h0000_0044);
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd0;
        step();
        issue_valid_i = 1'b0;
        check("x0_pending", pending_o, 32'd0);

        // Flush with a write in flight.
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd8;
        step();
        issue_rd_i    = 5'd9;
        step();
        issue_valid_i = 1'b0;
        check("fl_pending_pre", pending_o, 32'h0000_0300);
        flush_i      = 1'b1;
        req_rd_i     = {5'd0, 5'd0, 5'd10};
        req_data_i   = {32'h0, 32'h0, 32'hAAAA_000A};
        tb_bus.valid = 3'b001;
        #1;
        check("fl_gnt_run", 32'(tb_bus.gnt), 32'h1);
        step();
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd12;
        #1;
        check("fl_gnt_drain",   32'(tb_bus.gnt),   32'd0);
        check("fl_done_pulse",  32'(flush_done_o), 32'd1);
        check("fl_inflight_we", 32'(RegWrite_o),   32'd1);
        check("fl_inflight_rd", 32'(RD_address_o), 32'd10);
        check("fl_pending_mid", pending_o,         32'h0000_0300);
        step();
        flush_i       = 1'b0;
        issue_valid_i = 1'b0;
        #1;
        check("fl_done_end",   32'(flush_done_o), 32'd0);
        check("fl_pending_0",  pending_o,         32'd0);
        check("fl_we_end",     32'(RegWrite_o),   32'd0);
        check("fl_gnt_back",   32'(tb_bus.gnt),   32'h1);
        tb_bus.valid = 3'b000;
        step();

        // Asynchronous reset in mid-cycle discards a registered write.
        req_rd_i      = {5'd0, 5'd0, 5'd11};
        req_data_i    = {32'h0, 32'h0, 32'h0000_0B0B};
        tb_bus.valid  = 3'b001;
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd13;
        RS1_address_i = 5'd13;
        step();
        tb_bus.valid  = 3'b000;
        issue_valid_i = 1'b0;
        #1;
        check("ar_we_pre",      32'(RegWrite_o), 32'd1);
        check("ar_pending_pre", pending_o,       32'h0000_2000);
        check("ar_busy_pre",    32'(RS1_busy_o), 32'd1);
        rst_n_i      = 1'b0;
        tb_bus.valid = 3'b111;
        #1;
        check("ar_we",      32'(RegWrite_o),   32'd0);
        check("ar_pending", pending_o,         32'd0);
        check("ar_rd_addr", 32'(RD_address_o), 32'd0);
        check("ar_rd_data", RD_data_o,         32'd0);
        check("ar_busy",    32'(RS1_busy_o),   32'd0);
        check("ar_ready",   32'(tb_bus.gnt),   32'd0);
        step();
        tb_bus.valid = 3'b000;
        rst_n_i      = 1'b1;
        step();
        check("ar_we_after", 32'(RegWrite_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
